// File: rtl/dat_mem_arb.sv
// Two-port arbiter/sequencer for the byte-addressed data memory: one access in flight,
// legality screening, one-cycle read return. Define DAT_MEM_ARB_RR_EN for round-robin.
module dat_mem_arb #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdat,
  input  logic [2:0]  p0_funct,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdat,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdat,
  input  logic [2:0]  p1_funct,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdat,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdat,
  output logic [2:0]  mem_funct,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdat
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned FW = 3;
  localparam int unsigned SW = AW + 1;

  typedef enum logic [1:0] {IDLE, RD, ERR} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    logic [FW-1:0] funct;
  } req_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          sel;
  req_t          win;
  logic [SW-1:0] size;
  logic [1:0]    amask;
  logic          in_range, aligned, funct_ok, legal;

`ifdef DAT_MEM_ARB_RR_EN
  logic last_q;
  logic gnt_any;

  assign gnt_any = (state_q == IDLE) && (p0_req || p1_req);
  // On conflict the port not granted last wins; reset value favours port 0.
  assign sel = (p0_req && p1_req) ? ~last_q : ~p0_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_q <= 1'b1;
    else if (gnt_any) last_q <= sel;
  end
`else
  assign sel = ~p0_req;
`endif

  assign win = sel ? req_t'{p1_we, p1_addr, p1_wdat, p1_funct}
                   : req_t'{p0_we, p0_addr, p0_wdat, p0_funct};

  assign mem_addr  = win.addr;
  assign mem_wdat  = win.wdat;
  assign mem_funct = win.funct;

  // Access size and alignment mask from funct[1:0].
  always_comb begin
    size  = SW'(4);
    amask = 2'b11;
    unique case (win.funct[1:0])
      2'b00:   begin size = SW'(1); amask = 2'b00; end
      2'b01:   begin size = SW'(2); amask = 2'b01; end
      default: begin size = SW'(4); amask = 2'b11; end
    endcase
  end

  always_comb begin
    funct_ok = 1'b0;
    unique case (win.funct)
      3'b000, 3'b001, 3'b010: funct_ok = 1'b1;
      3'b100, 3'b101:         funct_ok = ~win.we;
      default:                funct_ok = 1'b0;
    endcase
  end

  // 33-bit end address so the top of the 32-bit space cannot wrap into range.
  assign in_range = ({1'b0, win.addr} + size) <= SW'(DEPTH);
  assign aligned  = (win.addr[1:0] & amask) == 2'b00;
  assign legal    = in_range && aligned && funct_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    p0_err    = 1'b0;
    p1_err    = 1'b0;
    p0_rdat   = '0;
    p1_rdat   = '0;
    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          p0_gnt  = ~sel;
          p1_gnt  = sel;
          owner_d = sel;
          if (!legal) begin
            state_d = ERR;
          end else if (win.we) begin
            mem_write = 1'b1;
          end else begin
            mem_read = 1'b1;
            state_d  = RD;
          end
        end
      end
      RD: begin
        state_d = IDLE;
        if (owner_q) begin
          p1_rvalid = 1'b1;
          p1_rdat   = mem_rdat;
        end else begin
          p0_rvalid = 1'b1;
          p0_rdat   = mem_rdat;
        end
      end
      ERR: begin
        state_d = IDLE;
        if (owner_q) begin
          p1_rvalid = 1'b1;
          p1_err    = 1'b1;
        end else begin
          p0_rvalid = 1'b1;
          p0_err    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dat_mem_arb.sv
// Scoreboard bench for dat_mem_arb: random two-port traffic against a reference model,
// then directed boundary, contention and reset cases.
module tb_dat_mem_arb;

  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we, gnt, rvalid, err;
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic [2:0]  funct [2];
  logic [31:0] mem_addr, mem_wdat, mem_rdat;
  logic [2:0]  mem_funct;
  logic        mem_read, mem_write;

  dat_mem_arb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdat(wdat[0]), .p0_funct(funct[0]),
    .p0_gnt(gnt[0]), .p0_rvalid(rvalid[0]), .p0_rdat(rdat[0]), .p0_err(err[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdat(wdat[1]), .p1_funct(funct[1]),
    .p1_gnt(gnt[1]), .p1_rvalid(rvalid[1]), .p1_rdat(rdat[1]), .p1_err(err[1]),
    .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_funct(mem_funct),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdat(mem_rdat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  dmem    [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] last_rdat [2];
  logic        last_err  [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f);
    return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic int idx(input logic [31:0] a, input int i);
    return int'((a + 32'(i)) & 32'(DEPTH - 1));
  endfunction

  // Memory-side extension of the raw little-endian word at the address.
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f);
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic bit ref_legal(input logic w, input logic [31:0] a, input logic [2:0] f);
    logic [63:0] end_a;
    bit fok;
    fok = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (!w && (f == 3'd4 || f == 3'd5));
    end_a = {32'd0, a} + 64'(nbytes(f));
    if (!fok) return 1'b0;
    if (end_a > 64'(DEPTH)) return 1'b0;
    if ((a % 32'(nbytes(f))) != 32'd0) return 1'b0;
    return 1'b1;
  endfunction

  // Behavioural data memory: writes at the edge ending the strobe cycle, registered read.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) dmem[i] = 8'h00;
    mem_rdat = 32'd0;
    forever begin
      @(posedge clk);
      if (mem_write)
        for (int i = 0; i < nbytes(mem_funct); i++) dmem[idx(mem_addr, i)] = mem_wdat[8*i +: 8];
      if (mem_read)
        mem_rdat = ext({dmem[idx(mem_addr, 3)], dmem[idx(mem_addr, 2)],
                        dmem[idx(mem_addr, 1)], dmem[idx(mem_addr, 0)]}, mem_funct);
    end
  end

  // Reference arbiter: predicts each grant, checks the memory side, queues the response.
  initial begin : ref_chk
    bit   busy;
    bit   ref_last;
    int   w;
    bit   lg;
    exp_t e;
    busy = 1'b0;
    ref_last = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q0.delete();
        q1.delete();
        busy = 1'b0;
        ref_last = 1'b1;
      end else if (busy) begin
        chk("gnt_while_busy", 32'(gnt), 32'd0);
        chk("strobe_while_busy", 32'({mem_read, mem_write}), 32'd0);
        busy = 1'b0;
      end else if (req == 2'b00) begin
        chk("gnt_no_req", 32'(gnt), 32'd0);
        chk("strobe_no_req", 32'({mem_read, mem_write}), 32'd0);
      end else begin
`ifdef DAT_MEM_ARB_RR_EN
        w = (req == 2'b11) ? (ref_last ? 0 : 1) : (req[0] ? 0 : 1);
`else
        w = req[0] ? 0 : 1;
`endif
        ref_last = w[0];
        lg = ref_legal(we[w], addr[w], funct[w]);
        chk("gnt", 32'(gnt), (w == 0) ? 32'd1 : 32'd2);
        chk("mem_addr", mem_addr, addr[w]);
        chk("mem_funct", 32'(mem_funct), 32'(funct[w]));
        if (!lg) begin
          chk("strobe_illegal", 32'({mem_read, mem_write}), 32'd0);
          e = '{cyc + 1, 1'b1, 32'd0};
          busy = 1'b1;
        end else if (we[w]) begin
          chk("strobe_store", 32'({mem_read, mem_write}), 32'd1);
          chk("mem_wdat", mem_wdat, wdat[w]);
          for (int i = 0; i < nbytes(funct[w]); i++) ref_mem[idx(addr[w], i)] = wdat[w][8*i +: 8];
        end else begin
          chk("strobe_load", 32'({mem_read, mem_write}), 32'd2);
          e = '{cyc + 1, 1'b0, ext({ref_mem[idx(addr[w], 3)], ref_mem[idx(addr[w], 2)],
                                    ref_mem[idx(addr[w], 1)], ref_mem[idx(addr[w], 0)]}, funct[w])};
          busy = 1'b1;
        end
        if (busy) begin
          if (w == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
    end
  end

  // Response monitor: pops the expected response whenever a port shows rvalid.
  initial begin : mon
    exp_t e;
    bit   empty;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int p = 0; p < 2; p++) begin
          if (rvalid[p]) begin
            empty = (p == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
              checks++;
              errors++;
              $display("FAIL unexpected_rvalid p%0d: got rvalid 1 expected 0 (cycle %0d)", p, cyc);
            end else begin
              e = (p == 0) ? q0.pop_front() : q1.pop_front();
              chk("rvalid_cycle", cyc, e.cyc);
              chk("rsp_err", 32'(err[p]), 32'(e.err));
              chk("rsp_rdat", rdat[p], e.data);
            end
            last_rdat[p] = rdat[p];
            last_err[p]  = err[p];
          end else begin
            chk("rdat_quiet", rdat[p], 32'd0);
            chk("err_quiet", 32'(err[p]), 32'd0);
          end
        end
      end
    end
  end

  task automatic rand_fields(input int p);
    logic [2:0]  f;
    logic [31:0] a;
    int          r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1:    f = 3'b010;
      2, 3:    f = 3'b000;
      4, 7:    f = 3'b001;
      5:       f = 3'b100;
      6:       f = 3'b101;
      default: f = 3'($urandom);
    endcase
    r = $urandom_range(0, 15);
    if (r < 10)       a = 32'($urandom_range(0, 63));
    else if (r < 13)  a = 32'(DEPTH - 8) + 32'($urandom_range(0, 11));
    else if (r == 13) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
    else              a = $urandom;
    if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(f)) - 32'd1);
    we[p]    = 1'($urandom_range(0, 1));
    addr[p]  = a;
    wdat[p]  = $urandom;
    funct[p] = f;
  endtask

  task automatic wait_gnt(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[p] && n < 50);
    if (!gnt[p]) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout p%0d: got no grant expected grant within 50 cycles", p);
    end
  endtask

  task automatic issue(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f);
    last_rdat[p] = 32'hxxxx_xxxx;
    last_err[p]  = 1'bx;
    @(posedge clk); #1;
    we[p] = w; addr[p] = a; wdat[p] = d; funct[p] = f; req[p] = 1'b1;
    wait_gnt(p);
    @(posedge clk); #1;
    req[p] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int   seq[$];
    logic [1:0] g;
    rst_n = 1'b0;
    req = 2'b00;
    we = 2'b00;
    for (int p = 0; p < 2; p++) begin
      addr[p] = 32'd0; wdat[p] = 32'd0; funct[p] = 3'd0;
    end
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_rdat0", rdat[0], 32'd0);
    chk("rst_rdat1", rdat[1], 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (req[p] && g[p]) req[p] = 1'b0;
        else if (req[p] && $urandom_range(0, 31) == 0) req[p] = 1'b0;
        if (!req[p] && $urandom_range(0, 2) == 0) begin
          rand_fields(p);
          req[p] = 1'b1;
        end
      end
    end
    @(posedge clk); #1 req = 2'b00;
    repeat (4) @(posedge clk);

    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010);
    issue(0, 1'b0, 32'h10, 32'd0, 3'b010);
    chk("tp_word_load", last_rdat[0], 32'hDEAD_BEEF);
    issue(1, 1'b0, 32'h13, 32'd0, 3'b000);
    chk("tp_lb", last_rdat[1], 32'hFFFF_FFDE);
    issue(1, 1'b0, 32'h13, 32'd0, 3'b100);
    chk("tp_lbu", last_rdat[1], 32'h0000_00DE);
    issue(0, 1'b0, 32'h12, 32'd0, 3'b010);
    chk("tp_misaligned_err", 32'(last_err[0]), 32'd1);
    chk("tp_misaligned_rdat", last_rdat[0], 32'd0);
    issue(0, 1'b0, 32'hFFC, 32'd0, 3'b010);
    chk("tp_top_word_ok", 32'(last_err[0]), 32'd0);
    issue(0, 1'b0, 32'h1000, 32'd0, 3'b010);
    chk("tp_past_end_err", 32'(last_err[0]), 32'd1);
    issue(0, 1'b0, 32'hFFFF_FFFF, 32'd0, 3'b010);
    chk("tp_wrap_err", 32'(last_err[0]), 32'd1);
    issue(0, 1'b1, 32'h10, 32'h1234_5678, 3'b100);
    chk("tp_store_bu_err", 32'(last_err[0]), 32'd1);
    issue(0, 1'b0, 32'h10, 32'd0, 3'b010);
    chk("tp_store_bu_unchanged", last_rdat[0], 32'hDEAD_BEEF);

    // Make port 1 the last winner, then hold both ports busy with loads.
    issue(1, 1'b0, 32'h20, 32'd0, 3'b010);
    @(posedge clk); #1;
    we = 2'b00;
    addr[0] = 32'h10; funct[0] = 3'b010;
    addr[1] = 32'h14; funct[1] = 3'b010;
    req = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (gnt[0]) seq.push_back(0);
      else if (gnt[1]) seq.push_back(1);
    end
    @(posedge clk); #1 req = 2'b00;
    repeat (3) @(posedge clk);
    chk("contend_grants", 32'(seq.size()), 32'd4);
    for (int k = 0; k < seq.size(); k++)
`ifdef DAT_MEM_ARB_RR_EN
      chk("contend_order", 32'(seq[k]), 32'(k % 2));
`else
      chk("contend_order", 32'(seq[k]), 32'd0);
`endif
    chk("pending_before_reset", 32'(q0.size() + q1.size()), 32'd0);

    // Reset during the read-return cycle discards the response.
    @(posedge clk); #1;
    we[0] = 1'b0; addr[0] = 32'h10; funct[0] = 3'b010; req[0] = 1'b1;
    wait_gnt(0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rd_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rd_gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    we[1] = 1'b0; addr[1] = 32'h10; funct[1] = 3'b010; req[1] = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'd2);
    @(posedge clk); #1 req[1] = 1'b0;
    repeat (3) @(posedge clk);
    chk("post_rst_load", last_rdat[1], 32'hDEAD_BEEF);
    chk("pending_at_end", 32'(q0.size() + q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
